// File: rtl/cc_cond_if.sv
// Bundle between the execute stage and the condition-code unit:
// ALU flag writes in, condition queries in, registered results and stats out.
interface cc_cond_if #(
    parameter int CNT_W = 16
);
    logic             alu_valid;
    logic [2:0]       alu_cf;
    logic             set_cc;
    logic             suppress;
    logic             stall;
    logic             query_valid;
    logic [3:0]       q_icode;
    logic [3:0]       q_ifun;
    logic [2:0]       cc;
    logic             cnd;
    logic             cnd_valid;
    logic             cnd_err;
    logic [CNT_W-1:0] query_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output alu_valid, alu_cf, set_cc, suppress, stall,
        output query_valid, q_icode, q_ifun,
        input  cc, cnd, cnd_valid, cnd_err, query_cnt, taken_cnt
    );

    modport slave (
        input  alu_valid, alu_cf, set_cc, suppress, stall,
        input  query_valid, q_icode, q_ifun,
        output cc, cnd, cnd_valid, cnd_err, query_cnt, taken_cnt
    );
endinterface

// File: rtl/cc_cond_unit.sv
// Y86-64 condition-code register plus registered jXX/cmovXX condition
// evaluator, with saturating query/taken statistics.
module cc_cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    cc_cond_if.slave  bus
);
    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    localparam logic [3:0] ICODE_CMOV = 4'd2;
    localparam logic [3:0] ICODE_JXX  = 4'd7;

    state_t           state;
    logic [2:0]       cc_q;
    logic             cnd_q;
    logic             err_q;
    logic [CNT_W-1:0] qcnt_q;
    logic [CNT_W-1:0] tcnt_q;

    logic zf;
    logic sf;
    logic of;
    logic lt;
    logic legal;
    logic cond;
    logic res;
    logic cc_wr;
    logic accept;

    assign zf = cc_q[0];
    assign sf = cc_q[1];
    assign of = cc_q[2];
    assign lt = sf ^ of;

    assign cc_wr  = bus.alu_valid & bus.set_cc
                  & ~bus.suppress & ~bus.stall;
    assign accept = bus.query_valid & ~bus.stall;

    assign legal = ((bus.q_icode == ICODE_CMOV) ||
                    (bus.q_icode == ICODE_JXX)) &&
                   (bus.q_ifun <= 4'd6);

    always_comb begin
        cond = 1'b0;
        unique case (bus.q_ifun)
            4'd0:    cond = 1'b1;
            4'd1:    cond = lt | zf;
            4'd2:    cond = lt;
            4'd3:    cond = zf;
            4'd4:    cond = ~zf;
            4'd5:    cond = ~lt;
            4'd6:    cond = ~lt & ~zf;
            default: cond = 1'b0;
        endcase
    end

    assign res = legal & cond;

    // Queries read cc_q before this edge's write lands: no bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cc_q   <= 3'b001;
            cnd_q  <= 1'b0;
            err_q  <= 1'b0;
            qcnt_q <= '0;
            tcnt_q <= '0;
        end else if (!bus.stall) begin
            if (cc_wr)
                cc_q <= bus.alu_cf;
            if (accept) begin
                state <= RESP;
                cnd_q <= res;
                err_q <= ~legal;
                if (qcnt_q != '1)
                    qcnt_q <= qcnt_q + CNT_W'(1);
                if (res && (tcnt_q != '1))
                    tcnt_q <= tcnt_q + CNT_W'(1);
            end else begin
                state <= IDLE;
            end
        end
    end

    assign bus.cc        = cc_q;
    assign bus.cnd       = cnd_q;
    assign bus.cnd_valid = (state == RESP);
    assign bus.cnd_err   = err_q;
    assign bus.query_cnt = qcnt_q;
    assign bus.taken_cnt = tcnt_q;
endmodule

// File: tb/tb_cc_cond_unit.sv
// Bench for cc_cond_unit: per-cycle comparison against a flag-level model
// plus directed literal expectations.
module tb_cc_cond_unit;
    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    cc_cond_if #(.CNT_W(W)) bus ();

    cc_cond_unit #(.CNT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state
    logic [2:0] m_cc;
    logic       m_v;
    logic       m_cnd;
    logic       m_err;
    int         m_q;
    int         m_t;

    function automatic logic eval(input logic [2:0] f,
                                  input logic [3:0] ic,
                                  input logic [3:0] fn);
        bit z, s, o, less;
        bit [6:0] tbl;
        z = f[0];
        s = f[1];
        o = f[2];
        less = (s != o);
        tbl[0] = 1'b1;
        tbl[1] = less || z;
        tbl[2] = less;
        tbl[3] = z;
        tbl[4] = !z;
        tbl[5] = !less;
        tbl[6] = !less && !z;
        if (!(ic == 4'd2 || ic == 4'd7) || fn > 4'd6)
            return 1'b0;
        return tbl[fn[2:0]];
    endfunction

    function automatic bit is_legal(input logic [3:0] ic,
                                    input logic [3:0] fn);
        return (ic == 4'd2 || ic == 4'd7) && fn <= 4'd6;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cc  = 3'b001;
            m_v   = 1'b0;
            m_cnd = 1'b0;
            m_err = 1'b0;
            m_q   = 0;
            m_t   = 0;
        end else if (!bus.stall) begin
            logic r;
            r = eval(m_cc, bus.q_icode, bus.q_ifun);
            if (bus.query_valid) begin
                m_v   = 1'b1;
                m_cnd = r;
                m_err = !is_legal(bus.q_icode, bus.q_ifun);
                m_q   = (m_q < MAX) ? m_q + 1 : MAX;
                if (r)
                    m_t = (m_t < MAX) ? m_t + 1 : MAX;
            end else begin
                m_v = 1'b0;
            end
            if (bus.alu_valid && bus.set_cc && !bus.suppress)
                m_cc = bus.alu_cf;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_cc", int'(bus.cc), int'(m_cc));
        chk("m_valid", int'(bus.cnd_valid), int'(m_v));
        chk("m_cnd", int'(bus.cnd), int'(m_cnd));
        chk("m_err", int'(bus.cnd_err), int'(m_err));
        chk("m_qcnt", int'(bus.query_cnt), m_q);
        chk("m_tcnt", int'(bus.taken_cnt), m_t);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_cf      = 3'b000;
        bus.set_cc      = 1'b0;
        bus.suppress    = 1'b0;
        bus.stall       = 1'b0;
        bus.query_valid = 1'b0;
        bus.q_icode     = 4'd0;
        bus.q_ifun      = 4'd0;
    endtask

    task automatic query(input logic [3:0] ic, input logic [3:0] fn);
        bus.query_valid = 1'b1;
        bus.q_icode     = ic;
        bus.q_ifun      = fn;
    endtask

    task automatic wr(input logic [2:0] f);
        bus.alu_valid = 1'b1;
        bus.set_cc    = 1'b1;
        bus.alu_cf    = f;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cc", int'(bus.cc), 1);
        chk("rst_valid", int'(bus.cnd_valid), 0);
        chk("rst_qcnt", int'(bus.query_cnt), 0);

        query(4'd7, 4'd3);
        tick();
        idle();
        chk("e_after_rst_v", int'(bus.cnd_valid), 1);
        chk("e_after_rst", int'(bus.cnd), 1);
        chk("e_after_rst_err", int'(bus.cnd_err), 0);

        wr(3'b010);
        tick();
        idle();
        chk("cc_010", int'(bus.cc), 2);
        query(4'd7, 4'd2);
        tick();
        chk("l_sf", int'(bus.cnd), 1);
        query(4'd2, 4'd5);
        tick();
        chk("ge_sf", int'(bus.cnd), 0);
        query(4'd7, 4'd6);
        tick();
        chk("g_sf", int'(bus.cnd), 0);
        idle();

        wr(3'b100);
        bus.suppress = 1'b1;
        tick();
        chk("suppress_blk", int'(bus.cc), 2);
        bus.suppress = 1'b0;
        bus.set_cc   = 1'b0;
        tick();
        chk("setcc_blk", int'(bus.cc), 2);
        bus.set_cc = 1'b1;
        tick();
        idle();
        chk("cc_100", int'(bus.cc), 4);
        query(4'd7, 4'd1);
        tick();
        idle();
        chk("le_of", int'(bus.cnd), 1);

        wr(3'b001);
        tick();
        wr(3'b000);
        query(4'd7, 4'd3);
        tick();
        idle();
        chk("hazard_old", int'(bus.cnd), 1);
        chk("hazard_cc", int'(bus.cc), 0);
        query(4'd7, 4'd3);
        tick();
        idle();
        chk("hazard_new", int'(bus.cnd), 0);

        query(4'd7, 4'd9);
        tick();
        chk("ill_ifun_cnd", int'(bus.cnd), 0);
        chk("ill_ifun_err", int'(bus.cnd_err), 1);
        chk("ill_qcnt", int'(bus.query_cnt), 8);
        chk("ill_tcnt", int'(bus.taken_cnt), 4);
        query(4'd3, 4'd0);
        tick();
        chk("ill_icode_err", int'(bus.cnd_err), 1);
        query(4'd7, 4'd0);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", int'(bus.cnd_valid), 1);
            chk("stall_qcnt", int'(bus.query_cnt), 9);
            chk("stall_err", int'(bus.cnd_err), 1);
        end
        idle();
        tick();
        chk("stall_release", int'(bus.cnd_valid), 0);

        query(4'd2, 4'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("burst_valid", int'(bus.cnd_valid), 1);
        end
        chk("sat_qcnt", int'(bus.query_cnt), MAX);
        chk("sat_tcnt", int'(bus.taken_cnt), MAX);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_cc", int'(bus.cc), 1);
        chk("mid_rst_valid", int'(bus.cnd_valid), 0);
        chk("mid_rst_cnd", int'(bus.cnd), 0);
        chk("mid_rst_qcnt", int'(bus.query_cnt), 0);
        chk("mid_rst_tcnt", int'(bus.taken_cnt), 0);
        tick();
        rst = 1'b0;
        query(4'd7, 4'd3);
        tick();
        idle();
        chk("post_rst_e", int'(bus.cnd), 1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
